// File: rtl/lfsr_arb_ctrl_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : lfsr_arb_ctrl_pkg                                                |
// | Brief  : FSM state encoding and LFSR width shared by the arbiter slice    |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
package lfsr_arb_ctrl_pkg;

    localparam int c_lfsr_w = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr_arb_ctrl_lfsr.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : LFSR_6bit                                                        |
// | Brief  : 6-bit Galois LFSR, sel=0 parallel load, sel=1 single step        |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module LFSR_6bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic [5:0] parallel_in,
    output logic [5:0] parallel_out
);

    // Bit 5 feeds back into bit 0 and is XORed into bits 1 and 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parallel_out <= '0;
        end else if (sel) begin
            parallel_out <= {parallel_out[4],
                             parallel_out[3],
                             parallel_out[2] ^ parallel_out[5],
                             parallel_out[1],
                             parallel_out[0] ^ parallel_out[5],
                             parallel_out[5]};
        end else begin
            parallel_out <= parallel_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_arb_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : lfsr_arb_ctrl                                                    |
// | Brief  : Round-robin sharing of one 6-bit LFSR between two requesters     |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module lfsr_arb_ctrl
    import lfsr_arb_ctrl_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [c_lfsr_w-1:0] req0_seed,
    input  logic [c_lfsr_w-1:0] req1_seed,
    input  logic [STEP_W-1:0]   req0_steps,
    input  logic [STEP_W-1:0]   req1_steps,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [c_lfsr_w-1:0] rsp_data,
    output logic                busy
);

    state_t              r_state;
    logic                r_rr;
    logic [STEP_W-1:0]   r_cnt;
    logic [STEP_W-1:0]   r_steps;
    logic [c_lfsr_w-1:0] r_seed;
    logic                r_id;
    logic                r_rsp_valid;

    logic                w_gnt_idx;
    logic                w_lfsr_sel;
    logic [c_lfsr_w-1:0] w_lfsr_in;
    logic [c_lfsr_w-1:0] w_lfsr_out;

    // Contention goes to the pointer; a lone requester always wins.
    assign w_gnt_idx = (req_valid == 2'b11) ? r_rr : req_valid[1];

    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == ST_IDLE) && (|req_valid)) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // The core has no hold mode, so idle states reload its own output.
    assign w_lfsr_sel = (r_state == ST_RUN);
    assign w_lfsr_in  = (r_state == ST_LOAD) ? r_seed : w_lfsr_out;

    LFSR_6bit u_lfsr (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel          (w_lfsr_sel),
        .parallel_in  (w_lfsr_in),
        .parallel_out (w_lfsr_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr        <= 1'b0;
            r_cnt       <= '0;
            r_steps     <= '0;
            r_seed      <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_seed  <= w_gnt_idx ? req1_seed  : req0_seed;
                        r_steps <= w_gnt_idx ? req1_steps : req0_steps;
                        r_cnt   <= w_gnt_idx ? req1_steps : req0_steps;
                        r_id    <= w_gnt_idx;
                        r_rr    <= ~w_gnt_idx;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_steps != '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - STEP_W'(1);
                    if (r_cnt == STEP_W'(1)) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = w_lfsr_out;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
